// File: rtl/spi_periph_regbank.sv
// rtl/spi_periph_regbank.sv - SPI peripheral with oversampled pins feeding a parametrised register bank
module spi_periph_regbank #(
    parameter int                   DATA_W      = 16,
    parameter int                   ADDR_W      = 3,
    parameter bit                   CPOL        = 1'b0,
    parameter bit                   CPHA        = 1'b0,
    parameter bit                   MSB_FIRST   = 1'b1,
    parameter int                   SYNC_STAGES = 2,
    parameter logic [2**ADDR_W-1:0] RO_MASK     = '0,
    parameter logic [DATA_W-1:0]    REG_RESET   = '0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            SCK,
    input  logic                            CS,
    input  logic                            COPI,
    output logic                            CIPO,
    output logic                            cipo_oe,
    input  logic [(2**ADDR_W)*DATA_W-1:0]   ro_data,
    output logic [(2**ADDR_W)*DATA_W-1:0]   reg_out,
    output logic                            wr_pulse,
    output logic [ADDR_W-1:0]               wr_addr,
    output logic                            rd_pulse,
    output logic [ADDR_W-1:0]               rd_addr,
    output logic                            frame_err,
    output logic                            busy
);
    localparam int NUM_REGS  = 2**ADDR_W;
    localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
    localparam int CW        = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] LAST_ADDR = CW'(ADDR_W);
    localparam logic [CW-1:0] LAST_BIT  = CW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
    logic                   sck_prev_q, sck_prev_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   rw_q, rw_d;
    logic [ADDR_W-1:0]      addr_q, addr_d, addr_shift;
    logic [DATA_W-1:0]      data_q, data_d, data_shift;
    logic [DATA_W-1:0]      sh_q, sh_d;
    logic                   cipo_q, cipo_d, oe_q, oe_d, busy_q, busy_d;
    logic                   wr_pend_q, wr_pend_d;
    logic                   wr_pulse_q, wr_pulse_d, rd_pulse_q, rd_pulse_d;
    logic                   frame_err_q, frame_err_d;
    logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0]      regs_q [NUM_REGS];
    logic [DATA_W-1:0]      regs_d [NUM_REGS];
    logic [DATA_W-1:0]      slot_arr [NUM_REGS];

    logic sck_s, cs_s, copi_s;
    logic lead_edge, trail_edge, sample_edge, drive_edge;

    // Read-only slots bypass the register file and track ro_data live
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_slot
        assign slot_arr[i] = RO_MASK[i] ? ro_data[i*DATA_W +: DATA_W] : regs_q[i];
        assign reg_out[i*DATA_W +: DATA_W] = slot_arr[i];
    end

    assign sck_s       = sck_sync_q[SYNC_STAGES-1];
    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign copi_s      = copi_sync_q[SYNC_STAGES-1];
    assign lead_edge   = (sck_s != sck_prev_q) && (sck_prev_q == CPOL);
    assign trail_edge  = (sck_s != sck_prev_q) && (sck_prev_q != CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign drive_edge  = CPHA ? lead_edge : trail_edge;
    assign addr_shift  = MSB_FIRST ? {addr_q[ADDR_W-2:0], copi_s} : {copi_s, addr_q[ADDR_W-1:1]};
    assign data_shift  = MSB_FIRST ? {data_q[DATA_W-2:0], copi_s} : {copi_s, data_q[DATA_W-1:1]};

    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], SCK};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], CS};
        copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], COPI};
        sck_prev_d  = sck_s;
        state_d     = state_q;
        cnt_d       = cnt_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        data_d      = data_q;
        sh_d        = sh_q;
        cipo_d      = cipo_q;
        oe_d        = oe_q;
        busy_d      = busy_q;
        wr_pend_d   = 1'b0;
        wr_pulse_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        rd_pulse_d  = 1'b0;
        rd_addr_d   = rd_addr_q;
        frame_err_d = 1'b0;
        regs_d      = regs_q;

        // The write lands one clk after the final sample, even if CS rises meanwhile
        if (wr_pend_q) begin
            regs_d[addr_q] = data_q;
            wr_pulse_d     = 1'b1;
            wr_addr_d      = addr_q;
        end

        case (state_q)
            IDLE: begin
                cipo_d = 1'b0;
                oe_d   = 1'b0;
                busy_d = 1'b0;
                if (!cs_s) begin
                    state_d = CMD;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    oe_d    = 1'b1;
                end
            end
            CMD: begin
                if (cs_s) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                    busy_d      = 1'b0;
                    oe_d        = 1'b0;
                    cipo_d      = 1'b0;
                end else if (sample_edge) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == '0) begin
                        rw_d = copi_s;
                    end else begin
                        addr_d = addr_shift;
                        if (cnt_q == LAST_ADDR) begin
                            state_d = DATA;
                            if (rw_q) begin
                                sh_d       = slot_arr[addr_shift];
                                rd_pulse_d = 1'b1;
                                rd_addr_d  = addr_shift;
                            end
                        end
                    end
                end
            end
            DATA: begin
                if (cs_s) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                    busy_d      = 1'b0;
                    oe_d        = 1'b0;
                    cipo_d      = 1'b0;
                end else begin
                    if (drive_edge && rw_q) begin
                        cipo_d = MSB_FIRST ? sh_q[DATA_W-1] : sh_q[0];
                        sh_d   = MSB_FIRST ? {sh_q[DATA_W-2:0], 1'b0} : {1'b0, sh_q[DATA_W-1:1]};
                    end
                    if (sample_edge) begin
                        cnt_d = cnt_q + CW'(1);
                        if (!rw_q) data_d = data_shift;
                        if (cnt_q == LAST_BIT) begin
                            state_d   = DONE;
                            cipo_d    = 1'b0;
                            wr_pend_d = !rw_q && !RO_MASK[addr_q];
                        end
                    end
                end
            end
            DONE: begin
                cipo_d = 1'b0;
                if (cs_s) begin
                    state_d = IDLE;
                    oe_d    = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_sync_q  <= {SYNC_STAGES{CPOL}};
            cs_sync_q   <= '1;
            copi_sync_q <= '0;
            sck_prev_q  <= CPOL;
            state_q     <= IDLE;
            cnt_q       <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            sh_q        <= '0;
            cipo_q      <= 1'b0;
            oe_q        <= 1'b0;
            busy_q      <= 1'b0;
            wr_pend_q   <= 1'b0;
            wr_pulse_q  <= 1'b0;
            wr_addr_q   <= '0;
            rd_pulse_q  <= 1'b0;
            rd_addr_q   <= '0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= REG_RESET;
        end else begin
            sck_sync_q  <= sck_sync_d;
            cs_sync_q   <= cs_sync_d;
            copi_sync_q <= copi_sync_d;
            sck_prev_q  <= sck_prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            sh_q        <= sh_d;
            cipo_q      <= cipo_d;
            oe_q        <= oe_d;
            busy_q      <= busy_d;
            wr_pend_q   <= wr_pend_d;
            wr_pulse_q  <= wr_pulse_d;
            wr_addr_q   <= wr_addr_d;
            rd_pulse_q  <= rd_pulse_d;
            rd_addr_q   <= rd_addr_d;
            frame_err_q <= frame_err_d;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign CIPO      = cipo_q;
    assign cipo_oe   = oe_q;
    assign busy      = busy_q;
    assign wr_pulse  = wr_pulse_q;
    assign wr_addr   = wr_addr_q;
    assign rd_pulse  = rd_pulse_q;
    assign rd_addr   = rd_addr_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_periph_regbank.sv
// tb/tb_spi_periph_regbank.sv - vector table plus event scoreboard for spi_periph_regbank
module tb_spi_periph_regbank;
    localparam int HALF = 8;

    logic clk = 1'b0;
    logic rst;
    logic sck_a, cs_a, copi_a, cipo_a, oe_a, wrp_a, rdp_a, fe_a, busy_a;
    logic sck_b, cs_b, copi_b, cipo_b, oe_b, wrp_b, rdp_b, fe_b, busy_b;
    logic [2:0]   wra_a, rda_a, wra_b, rda_b;
    logic [127:0] ro_a, reg_a, ro_b, reg_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        bit          sel;
        bit          rw;
        logic [2:0]  addr;
        logic [15:0] data;
        int          nbits;
        bit          exp_wr;
        bit          exp_err;
        logic [15:0] exp_val;
    } vec_t;

    wr_t        wr_qa[$], wr_qb[$];
    logic [2:0] rd_qa[$], rd_qb[$];
    bit         err_qa[$], err_qb[$];

    always #5 clk = ~clk;

    spi_periph_regbank #(.RO_MASK(8'h80)) dut_a (
        .clk(clk), .rst(rst), .SCK(sck_a), .CS(cs_a), .COPI(copi_a),
        .CIPO(cipo_a), .cipo_oe(oe_a), .ro_data(ro_a), .reg_out(reg_a),
        .wr_pulse(wrp_a), .wr_addr(wra_a), .rd_pulse(rdp_a), .rd_addr(rda_a),
        .frame_err(fe_a), .busy(busy_a)
    );

    spi_periph_regbank #(.CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .SCK(sck_b), .CS(cs_b), .COPI(copi_b),
        .CIPO(cipo_b), .cipo_oe(oe_b), .ro_data(ro_b), .reg_out(reg_b),
        .wr_pulse(wrp_b), .wr_addr(wra_b), .rd_pulse(rdp_b), .rd_addr(rda_b),
        .frame_err(fe_b), .busy(busy_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic s, input logic c, input logic d);
        if (sel) begin sck_b = s; cs_b = c; copi_b = d; end
        else     begin sck_a = s; cs_a = c; copi_a = d; end
    endtask

    function automatic logic [15:0] slot(input bit sel, input int i);
        return sel ? reg_b[i*16 +: 16] : reg_a[i*16 +: 16];
    endfunction

    task automatic spi_xfer(input bit sel, input bit rw, input logic [2:0] addr, input logic [15:0] data,
                            input int nbits, input bit release_cs, output logic [15:0] rx);
        bit cpol, cpha, msb;
        logic [19:0] bits;
        logic c;
        cpol = sel; cpha = sel; msb = !sel;
        bits[0] = rw;
        for (int i = 0; i < 3; i++)  bits[1+i] = msb ? addr[2-i] : addr[i];
        for (int i = 0; i < 16; i++) bits[4+i] = msb ? data[15-i] : data[i];
        rx = '0;
        drive(sel, cpol, 1'b0, 1'b0);
        wait_clks(HALF);
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                drive(sel, cpol, 1'b0, bits[i]);
                wait_clks(HALF);
                c = sel ? cipo_b : cipo_a;
                drive(sel, !cpol, 1'b0, bits[i]);
                wait_clks(HALF);
                drive(sel, cpol, 1'b0, bits[i]);
            end else begin
                drive(sel, !cpol, 1'b0, bits[i]);
                wait_clks(HALF);
                c = sel ? cipo_b : cipo_a;
                drive(sel, cpol, 1'b0, bits[i]);
                wait_clks(HALF);
            end
            if (i >= 4) begin
                if (msb) rx[15-(i-4)] = c;
                else     rx[i-4] = c;
            end
            if (i == 2) begin
                chk("busy in frame", sel ? busy_b : busy_a, 1);
                chk("cipo_oe in frame", sel ? oe_b : oe_a, 1);
                chk("cipo in cmd", c, 0);
            end
        end
        if (release_cs) begin
            wait_clks(HALF);
            drive(sel, cpol, 1'b1, 1'b0);
            wait_clks(8);
        end
    endtask

    task automatic mon(input bit sel, input logic wp, input logic [2:0] wa, input logic rp,
                       input logic [2:0] ra, input logic fe, input logic [127:0] regs);
        wr_t e;
        logic [2:0] a;
        int n;
        if (wp) begin
            n = sel ? wr_qb.size() : wr_qa.size();
            chk("wr_pulse expected", 32'(n != 0), 1);
            if (n != 0) begin
                if (sel) e = wr_qb.pop_front(); else e = wr_qa.pop_front();
                chk("wr_addr", wa, e.addr);
                chk("slot at wr_pulse", regs[e.addr*16 +: 16], e.data);
            end
        end
        if (rp) begin
            n = sel ? rd_qb.size() : rd_qa.size();
            chk("rd_pulse expected", 32'(n != 0), 1);
            if (n != 0) begin
                if (sel) a = rd_qb.pop_front(); else a = rd_qa.pop_front();
                chk("rd_addr", ra, a);
            end
        end
        if (fe) begin
            n = sel ? err_qb.size() : err_qa.size();
            chk("frame_err expected", 32'(n != 0), 1);
            if (n != 0) begin
                if (sel) void'(err_qb.pop_front()); else void'(err_qa.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        mon(1'b0, wrp_a, wra_a, rdp_a, rda_a, fe_a, reg_a);
        mon(1'b1, wrp_b, wra_b, rdp_b, rda_b, fe_b, reg_b);
    end

    initial begin
        vec_t vecs[12];
        logic [15:0] exp_a[8];
        logic [15:0] rx;
        wr_t w;

        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        ro_a = '0;
        ro_a[7*16 +: 16] = 16'hBEEF;
        ro_a[5*16 +: 16] = 16'hDEAD;
        ro_b = '0;
        wait_clks(4);
        chk("rst cipo", cipo_a, 0);
        chk("rst cipo_oe", oe_a, 0);
        chk("rst busy", busy_a, 0);
        chk("rst pulses", {wrp_a, rdp_a, fe_a}, 0);
        chk("rst wr_addr", wra_a, 0);
        chk("rst rd_addr", rda_a, 0);
        chk("rst slot5", slot(0, 5), 16'h0000);
        chk("rst slot7 ro", slot(0, 7), 16'hBEEF);
        rst = 1'b1;
        wait_clks(4);

        vecs[0]  = '{0, 1'b0, 3'd5, 16'hA5C3, 20, 1, 0, 16'hA5C3};
        vecs[1]  = '{0, 1'b1, 3'd5, 16'h0000, 20, 0, 0, 16'hA5C3};
        vecs[2]  = '{0, 1'b0, 3'd7, 16'h0000, 20, 0, 0, 16'hBEEF};
        vecs[3]  = '{0, 1'b1, 3'd7, 16'h0000, 20, 0, 0, 16'hBEEF};
        vecs[4]  = '{0, 1'b0, 3'd1, 16'h5A5A, 10, 0, 1, 16'h0000};
        vecs[5]  = '{0, 1'b0, 3'd1, 16'h0F0F, 20, 1, 0, 16'h0F0F};
        vecs[6]  = '{0, 1'b1, 3'd1, 16'h0000, 20, 0, 0, 16'h0F0F};
        vecs[7]  = '{1, 1'b0, 3'd2, 16'h1234, 20, 1, 0, 16'h1234};
        vecs[8]  = '{1, 1'b1, 3'd2, 16'h0000, 20, 0, 0, 16'h1234};
        vecs[9]  = '{1, 1'b0, 3'd6, 16'h8001, 20, 1, 0, 16'h8001};
        vecs[10] = '{1, 1'b1, 3'd6, 16'h0000, 20, 0, 0, 16'h8001};
        vecs[11] = '{1, 1'b1, 3'd2, 16'h0000, 20, 0, 0, 16'h1234};

        for (int i = 0; i < 12; i++) begin
            vec_t v;
            v = vecs[i];
            w.addr = v.addr;
            w.data = v.data;
            if (v.exp_wr) begin
                if (v.sel) wr_qb.push_back(w); else wr_qa.push_back(w);
            end
            if (v.rw && v.nbits == 20) begin
                if (v.sel) rd_qb.push_back(v.addr); else rd_qa.push_back(v.addr);
            end
            if (v.exp_err) begin
                if (v.sel) err_qb.push_back(1'b1); else err_qa.push_back(1'b1);
            end
            spi_xfer(v.sel, v.rw, v.addr, v.data, v.nbits, 1'b1, rx);
            if (v.rw) chk($sformatf("vec%0d rx", i), rx, v.exp_val);
            else      chk($sformatf("vec%0d slot", i), slot(v.sel, v.addr), v.exp_val);
            chk($sformatf("vec%0d idle cipo", i), v.sel ? cipo_b : cipo_a, 0);
            chk($sformatf("vec%0d idle oe", i), v.sel ? oe_b : oe_a, 0);
            chk($sformatf("vec%0d idle busy", i), v.sel ? busy_b : busy_a, 0);
        end

        exp_a = '{16'h0000, 16'h0F0F, 16'h0000, 16'h0000, 16'h0000, 16'hA5C3, 16'h0000, 16'hBEEF};
        for (int i = 0; i < 8; i++) chk($sformatf("final slot%0d", i), slot(0, i), exp_a[i]);

        // CS latency and abort before any SCK edge
        err_qa.push_back(1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        wait_clks(2);
        chk("busy before latency", busy_a, 0);
        wait_clks(1);
        chk("busy at latency", busy_a, 1);
        chk("oe at latency", oe_a, 1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        wait_clks(8);
        chk("abort cmd busy", busy_a, 0);

        // Reset asserted in the middle of a write to addr 3
        spi_xfer(1'b0, 1'b0, 3'd3, 16'hFFFF, 12, 1'b0, rx);
        #3 rst = 1'b0;
        wait_clks(2);
        chk("midrst cipo", cipo_a, 0);
        chk("midrst oe", oe_a, 0);
        chk("midrst busy", busy_a, 0);
        chk("midrst wr_addr", wra_a, 0);
        chk("midrst rd_addr", rda_a, 0);
        chk("midrst slot3", slot(0, 3), 16'h0000);
        chk("midrst slot1", slot(0, 1), 16'h0000);
        chk("midrst slot7", slot(0, 7), 16'hBEEF);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        wait_clks(6);
        rst = 1'b1;
        wait_clks(4);
        w.addr = 3'd3;
        w.data = 16'hFFFF;
        wr_qa.push_back(w);
        spi_xfer(1'b0, 1'b0, 3'd3, 16'hFFFF, 20, 1'b1, rx);
        chk("post-rst slot3", slot(0, 3), 16'hFFFF);
        rd_qa.push_back(3'd3);
        spi_xfer(1'b0, 1'b1, 3'd3, 16'h0000, 20, 1'b1, rx);
        chk("post-rst rx3", rx, 16'hFFFF);

        wait_clks(4);
        chk("wr events a pending", wr_qa.size(), 0);
        chk("wr events b pending", wr_qb.size(), 0);
        chk("rd events a pending", rd_qa.size(), 0);
        chk("rd events b pending", rd_qb.size(), 0);
        chk("err events a pending", err_qa.size(), 0);
        chk("err events b pending", err_qb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
